// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte outputs of uart_rx
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_done,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_done,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error detect
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, idx_nxt;
    logic [7:0]  shift_reg, shift_nxt;
    logic [7:0]  data_reg, data_nxt;
    logic        done_reg, done_nxt;
    logic        ferr_reg, ferr_nxt;
    logic        rx_meta, rx_s;

    // Line is idle-high, so the synchronizer resets high to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= idx_nxt;
            shift_reg <= shift_nxt;
            data_reg  <= data_nxt;
            done_reg  <= done_nxt;
            ferr_reg  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift_reg;
        data_nxt  = data_reg;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    idx_nxt            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shift_reg;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            WAIT_IDLE: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.rx_data   = data_reg;
    assign bus.rx_done   = done_reg;
    assign bus.frame_err = ferr_reg;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk;
    logic rst;
    uart_rx_if u_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] exp_q[$];
    int         done_cyc[$];
    logic [7:0] last_data = 8'h00;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            last_data = u_if.rx_data;
            prev_done = 1'b0;
            prev_ferr = 1'b0;
        end else begin
            if (u_if.rx_done || u_if.frame_err)
                check("done_ferr_overlap", {31'd0, u_if.rx_done & u_if.frame_err}, 0);
            if (u_if.rx_done) begin
                check("done_single_cycle", {31'd0, prev_done}, 0);
                done_cnt++;
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("rx_data", {24'd0, u_if.rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (u_if.frame_err) begin
                check("ferr_single_cycle", {31'd0, prev_ferr}, 0);
                ferr_cnt++;
            end
            if (u_if.rx_data !== last_data)
                check("data_change_without_done", {31'd0, u_if.rx_done}, 1);
            last_data = u_if.rx_data;
            prev_done = u_if.rx_done;
            prev_ferr = u_if.frame_err;
        end
    end

    // Each bit starts 3 ns after a rising edge and lasts exactly CPB clocks.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            #3;
            u_if.rx = frame[i];
            repeat (CPB - 1) @(posedge clk);
        end
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1, 10);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    int  t0, base_done, base_ferr, lat;
    logic saw_busy;

    initial begin
        u_if.rx = 1'b1;
        rst = 1'b1;
        #1;
        check("reset_rx_data", {24'd0, u_if.rx_data}, 0);
        check("reset_rx_done", {31'd0, u_if.rx_done}, 0);
        check("reset_frame_err", {31'd0, u_if.frame_err}, 0);
        check("reset_busy", {31'd0, u_if.busy}, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);

        // single byte plus start-edge-to-done latency
        base_done = done_cnt;
        @(posedge clk);
        #3;
        t0 = cyc;
        exp_q.push_back(8'hA5);
        u_if.rx = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        begin
            logic [7:0] d;
            d = 8'hA5;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #3;
                u_if.rx = d[i];
                repeat (CPB - 1) @(posedge clk);
            end
            @(posedge clk);
            #3;
            u_if.rx = 1'b1;
            repeat (CPB - 1) @(posedge clk);
        end
        wait_drain("a5_drain");
        check("a5_done_count", done_cnt - base_done, 1);
        lat = done_cyc[done_cyc.size() - 1] - t0;
        check("a5_latency_in_154pm1", {31'd0, (lat >= 153 && lat <= 155)}, 1);
        check("a5_no_ferr", ferr_cnt, 0);

        // back-to-back frames
        base_done = done_cnt;
        send_good(8'h12);
        send_good(8'h34);
        wait_drain("b2b_drain");
        check("b2b_done_count", done_cnt - base_done, 2);
        check("b2b_spacing", done_cyc[done_cyc.size() - 1] - done_cyc[done_cyc.size() - 2], 160);

        // start glitch
        base_done = done_cnt;
        base_ferr = ferr_cnt;
        saw_busy = 1'b0;
        @(posedge clk);
        #3 u_if.rx = 1'b0;
        repeat (4) @(posedge clk);
        #3 u_if.rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (u_if.busy) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", {31'd0, saw_busy}, 1);
        check("glitch_busy_end", {31'd0, u_if.busy}, 0);
        check("glitch_no_done", done_cnt - base_done, 0);
        check("glitch_no_ferr", ferr_cnt - base_ferr, 0);
        check("glitch_data_kept", {24'd0, u_if.rx_data}, 32'h34);

        // framing error, line held low afterwards
        base_done = done_cnt;
        base_ferr = ferr_cnt;
        send_frame(8'hFF, 1'b0, 10);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("ferr_busy_while_low", {31'd0, u_if.busy}, 1);
        check("ferr_pulse_count", ferr_cnt - base_ferr, 1);
        check("ferr_no_done", done_cnt - base_done, 0);
        check("ferr_data_kept", {24'd0, u_if.rx_data}, 32'h34);
        @(posedge clk);
        #3 u_if.rx = 1'b1;
        repeat (5) @(negedge clk);
        check("ferr_busy_released", {31'd0, u_if.busy}, 0);
        send_good(8'h5A);
        wait_drain("after_ferr_drain");

        // async reset during data bit 3
        base_done = done_cnt;
        base_ferr = ferr_cnt;
        send_frame(8'hC3, 1'b1, 5);
        check("pre_reset_busy", {31'd0, u_if.busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, u_if.busy}, 0);
        check("async_rst_data", {24'd0, u_if.rx_data}, 0);
        check("async_rst_done", {31'd0, u_if.rx_done}, 0);
        check("async_rst_ferr", {31'd0, u_if.frame_err}, 0);
        u_if.rx = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        repeat (CPB * 12) @(negedge clk);
        check("rst_no_done", done_cnt - base_done, 0);
        check("rst_no_ferr", ferr_cnt - base_ferr, 0);
        send_good(8'h3C);
        wait_drain("after_rst_drain");

        // byte pair for downstream word assembly
        base_done = done_cnt;
        send_good(8'hDE);
        send_good(8'hAD);
        wait_drain("pair_drain");
        check("pair_done_count", done_cnt - base_done, 2);

        check("total_done", done_cnt, 7);
        check("total_ferr", ferr_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
